// File: rtl/mult_round_pack.sv
// mult_round_pack: FPU multiplier normalise, round-to-nearest-even and pack stage.
// Define FPU_MULT_INEXACT_EN to add the Inexact_flag output.
module mult_round_pack #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Sgn_Info,
    input  logic [EW+1:0]   Exp_in,
    input  logic [2*SW+1:0] Sgf_prod,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    Result,
    output logic            Overflow_flag,
    output logic            Underflow_flag,
    output logic            out_valid,
    input  logic            out_ready
`ifdef FPU_MULT_INEXACT_EN
    ,
    output logic            Inexact_flag
`endif
);

    localparam int PW = 2*SW+2;
    localparam int XW = EW+3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_PACK  = 2'd3;

    localparam logic [XW-2:0] EXP_MAX = {2'b00, {EW{1'b1}}};

    logic [1:0]    state;
    logic          sgn_q;
    logic [XW-1:0] exp_q;
    logic [PW-1:0] prod_q;
    logic [SW-1:0] mant_q;
    logic          guard_q;
    logic          sticky_q;
    logic          zero_q;

    logic [SW-1:0] mant_n;
    logic          guard_n;
    logic          sticky_n;
    logic          rnd_inc;
    logic [SW:0]   mant_sum;
    logic [W-1:0]  res_n;
    logic          ovf_n;
    logic          unf_n;

    assign in_ready = (state == S_IDLE);

    assign mant_n   = prod_q[PW-1] ? prod_q[PW-2:SW+1] : prod_q[PW-3:SW];
    assign guard_n  = prod_q[PW-1] ? prod_q[SW] : prod_q[SW-1];
    assign sticky_n = prod_q[PW-1] ? |prod_q[SW-1:0] : |prod_q[SW-2:0];

    assign rnd_inc  = guard_q & (sticky_q | mant_q[0]);
    assign mant_sum = {1'b0, mant_q} + {{SW{1'b0}}, rnd_inc};

    // Exponent is signed with spare headroom; the top bit is its sign.
    always_comb begin
        res_n = {sgn_q, exp_q[EW-1:0], mant_q};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (zero_q) begin
            res_n = {sgn_q, {(W-1){1'b0}}};
        end else if (!exp_q[XW-1] && (exp_q[XW-2:0] >= EXP_MAX)) begin
            res_n = {sgn_q, {EW{1'b1}}, {SW{1'b0}}};
            ovf_n = 1'b1;
        end else if (exp_q[XW-1] || (exp_q == '0)) begin
            res_n = {sgn_q, {(W-1){1'b0}}};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            sgn_q          <= 1'b0;
            exp_q          <= '0;
            prod_q         <= '0;
            mant_q         <= '0;
            guard_q        <= 1'b0;
            sticky_q       <= 1'b0;
            zero_q         <= 1'b0;
            Result         <= '0;
            Overflow_flag  <= 1'b0;
            Underflow_flag <= 1'b0;
            out_valid      <= 1'b0;
`ifdef FPU_MULT_INEXACT_EN
            Inexact_flag   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sgn_q  <= Sgn_Info;
                        exp_q  <= {Exp_in[EW+1], Exp_in};
                        prod_q <= Sgf_prod;
                        state  <= S_NORM;
                    end
                end
                S_NORM: begin
                    mant_q   <= mant_n;
                    guard_q  <= guard_n;
                    sticky_q <= sticky_n;
                    zero_q   <= (prod_q == '0);
                    if (prod_q[PW-1])
                        exp_q <= exp_q + {{(XW-1){1'b0}}, 1'b1};
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    mant_q <= mant_sum[SW-1:0];
                    exp_q  <= exp_q + {{(XW-1){1'b0}}, mant_sum[SW]};
                    state  <= S_PACK;
                end
                S_PACK: begin
                    // First PACK cycle registers the packed word; then hold for the handshake.
                    if (!out_valid) begin
                        Result         <= res_n;
                        Overflow_flag  <= ovf_n;
                        Underflow_flag <= unf_n;
                        out_valid      <= 1'b1;
`ifdef FPU_MULT_INEXACT_EN
                        Inexact_flag   <= ~zero_q &
                                          (guard_q | sticky_q | ovf_n | unf_n);
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
